win_checker: RTL and testbench

- Sequential four-in-a-row detector that sits directly downstream of the Connect 4 placement logic.
- After each accepted placement it receives the flattened board and the coordinates of the new piece, then walks outward from that cell in all four line directions, one cell per clock.
- It reports a sticky win with the winner, or a draw when the board fills, and tracks the total move count.
- Its win output drives the game FSM's win input.

---
 rtl/win_checker_if.sv | 28 ++
 rtl/win_checker.sv | 181 ++++++++++++++++++
 tb/tb_win_checker.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/win_checker_if.sv
// Placement-to-checker link: new-move request from the placement stage and
// the scan status / game result returned by the win checker.
interface win_checker_if #(
    parameter int ROWS = 6,
    parameter int COLS = 7
) ();
    logic                     start;
    logic [2*ROWS*COLS-1:0]   board;
    logic [2:0]               place_row;
    logic [2:0]               place_col;
    logic [1:0]               player;
    logic                     busy;
    logic                     done;
    logic                     win;
    logic [1:0]               winner;
    logic                     draw;
    logic [5:0]               moves;

    modport master (
        output start, board, place_row, place_col, player,
        input  busy, done, win, winner, draw, moves
    );

    modport slave (
        input  start, board, place_row, place_col, player,
        output busy, done, win, winner, draw, moves
    );
endinterface

// File: rtl/win_checker.sv
// Connect-4 win/draw detector: walks outward from the newest piece one cell
// per clock in each of the four line directions and keeps a sticky result.
module win_checker #(
    parameter int ROWS    = 6,
    parameter int COLS    = 7,
    parameter int WIN_LEN = 4
) (
    input  logic          CLOCK_50,
    input  logic          Resetn,
    win_checker_if.slave  bus_io
);
    localparam int                 CELLS     = ROWS * COLS;
    localparam logic [5:0]         CELLS_V   = CELLS[5:0];
    localparam logic [3:0]         ROWS_U    = ROWS[3:0];
    localparam logic [3:0]         COLS_U    = COLS[3:0];
    localparam logic signed [4:0]  ROWS_S    = ROWS[4:0];
    localparam logic signed [4:0]  COLS_S    = COLS[4:0];
    localparam logic [3:0]         WIN_LEN_V = WIN_LEN[3:0];
    localparam logic [3:0]         LAST_OFF  = WIN_LEN_V - 4'd1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_POS,
        S_NEG,
        S_EVAL,
        S_DONE
    } state_t;

    state_t      state_q;
    logic [2:0]  row_q;
    logic [2:0]  col_q;
    logic [1:0]  player_q;
    logic [1:0]  dir_q;
    logic [3:0]  run_q;
    logic [3:0]  off_q;
    logic        busy_q;
    logic        done_q;
    logic        win_q;
    logic [1:0]  winner_q;
    logic        draw_q;
    logic [5:0]  moves_q;

    logic               move_ok;
    logic signed [4:0]  dr_s;
    logic signed [4:0]  dc_s;
    logic signed [4:0]  step_s;
    logic signed [4:0]  probe_r;
    logic signed [4:0]  probe_c;
    logic               in_bounds;
    int                 probe_idx;
    logic [1:0]         probe_cell;
    logic               hit;

    // Decide whether the incoming move is legal.
    always_comb begin
        move_ok = ({1'b0, bus_io.place_row} < ROWS_U) &&
                  ({1'b0, bus_io.place_col} < COLS_U) &&
                  ((bus_io.player == 2'b01) || (bus_io.player == 2'b10));
    end

    // Probe the cell at the current offset; NEG walks the negated direction.
    always_comb begin
        dr_s = 5'sd0;
        dc_s = 5'sd0;
        case (dir_q)
            2'd0:    begin dr_s = 5'sd0; dc_s = 5'sd1;  end
            2'd1:    begin dr_s = 5'sd1; dc_s = 5'sd0;  end
            2'd2:    begin dr_s = 5'sd1; dc_s = 5'sd1;  end
            2'd3:    begin dr_s = 5'sd1; dc_s = -5'sd1; end
            default: begin dr_s = 5'sd0; dc_s = 5'sd0;  end
        endcase
        step_s  = (state_q == S_NEG) ? -$signed({1'b0, off_q}) : $signed({1'b0, off_q});
        probe_r = $signed({2'b00, row_q}) + step_s * dr_s;
        probe_c = $signed({2'b00, col_q}) + step_s * dc_s;
        in_bounds = (probe_r >= 5'sd0) && (probe_r < ROWS_S) &&
                    (probe_c >= 5'sd0) && (probe_c < COLS_S);
        probe_idx  = int'(probe_r[2:0]) * COLS + int'(probe_c[2:0]);
        probe_cell = 2'b00;
        for (int k = 0; k < CELLS; k++) begin
            probe_cell = probe_cell | ((probe_idx == k) ? bus_io.board[2*k +: 2] : 2'b00);
        end
        hit = in_bounds && (probe_cell == player_q);
    end

    // Scan sequencer with registered status and sticky result outputs.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            state_q  <= S_IDLE;
            row_q    <= 3'd0;
            col_q    <= 3'd0;
            player_q <= 2'b00;
            dir_q    <= 2'd0;
            run_q    <= 4'd0;
            off_q    <= 4'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            win_q    <= 1'b0;
            winner_q <= 2'b00;
            draw_q   <= 1'b0;
            moves_q  <= 6'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus_io.start && !win_q && !draw_q) begin
                        if (move_ok) begin
                            row_q    <= bus_io.place_row;
                            col_q    <= bus_io.place_col;
                            player_q <= bus_io.player;
                            moves_q  <= moves_q + 6'd1;
                            busy_q   <= 1'b1;
                            state_q  <= S_LOAD;
                        end else begin
                            // Illegal move: acknowledge without touching the game state.
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_LOAD: begin
                    dir_q   <= 2'd0;
                    run_q   <= 4'd1;
                    off_q   <= 4'd1;
                    state_q <= S_POS;
                end
                S_POS, S_NEG: begin
                    if (hit) begin
                        run_q <= run_q + 4'd1;
                        if ((run_q + 4'd1) >= WIN_LEN_V) begin
                            state_q <= S_EVAL;
                        end else if (off_q >= LAST_OFF) begin
                            off_q   <= 4'd1;
                            state_q <= (state_q == S_POS) ? S_NEG : S_EVAL;
                        end else begin
                            off_q <= off_q + 4'd1;
                        end
                    end else begin
                        off_q   <= 4'd1;
                        state_q <= (state_q == S_POS) ? S_NEG : S_EVAL;
                    end
                end
                S_EVAL: begin
                    if (run_q >= WIN_LEN_V) begin
                        win_q    <= 1'b1;
                        winner_q <= player_q;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end else if (dir_q == 2'd3) begin
                        draw_q  <= (moves_q == CELLS_V);
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        dir_q   <= dir_q + 2'd1;
                        run_q   <= 4'd1;
                        off_q   <= 4'd1;
                        state_q <= S_POS;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus_io.busy   = busy_q;
    assign bus_io.done   = done_q;
    assign bus_io.win    = win_q;
    assign bus_io.winner = winner_q;
    assign bus_io.draw   = draw_q;
    assign bus_io.moves  = moves_q;
endmodule

// File: tb/tb_win_checker.sv
// Bench for win_checker: fixed vector table, hand-written corner sequences and
// random games scored against a line-counting reference of the board.
module tb_win_checker;
    localparam int ROWS    = 6;
    localparam int COLS    = 7;
    localparam int WIN_LEN = 4;
    localparam int CELLS   = ROWS * COLS;

    logic CLOCK_50 = 1'b0;
    logic Resetn   = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    win_checker_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

    win_checker #(.ROWS(ROWS), .COLS(COLS), .WIN_LEN(WIN_LEN)) dut (
        .CLOCK_50 (CLOCK_50),
        .Resetn   (Resetn),
        .bus_io   (bus)
    );

    int errors = 0;
    int checks = 0;
    int bd [ROWS][COLS];
    bit m_win;
    bit m_draw;
    int m_winner;
    int m_moves;

    typedef struct packed {
        logic [2:0]  n;
        logic [31:0] pcs;
        logic [2:0]  row;
        logic [2:0]  col;
        logic [1:0]  pl;
        logic        exp_bad;
        logic        exp_win;
        logic [1:0]  exp_winner;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic logic [7:0] pc(input int r, input int c, input int p);
        return {3'(r), 3'(c), 2'(p)};
    endfunction

    function automatic logic [2*CELLS-1:0] pack_board();
        logic [2*CELLS-1:0] v;
        v = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                v[2*(r*COLS+c) +: 2] = 2'(bd[r][c]);
        return v;
    endfunction

    // Count same-owner cells on both sides of (r,c) along each of the four lines.
    function automatic bit ref_win(input int r, input int c, input int p);
        int dr [4] = '{0, 1, 1, 1};
        int dc [4] = '{1, 0, 1, -1};
        for (int d = 0; d < 4; d++) begin
            int cnt = 1;
            for (int s = -1; s <= 1; s += 2) begin
                for (int k = 1; k < WIN_LEN; k++) begin
                    int rr = r + s * k * dr[d];
                    int cc = c + s * k * dc[d];
                    if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) break;
                    if (bd[rr][cc] != p) break;
                    cnt++;
                end
            end
            if (cnt >= WIN_LEN) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, "_win"},    bus.win,    m_win);
        chk({tag, "_winner"}, bus.winner, m_winner);
        chk({tag, "_draw"},   bus.draw,   m_draw);
        chk({tag, "_moves"},  bus.moves,  m_moves);
        chk({tag, "_busy"},   bus.busy,   0);
    endtask

    task automatic do_reset();
        Resetn    = 1'b0;
        bus.start = 1'b0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                bd[r][c] = 0;
        m_win = 0; m_draw = 0; m_winner = 0; m_moves = 0;
        @(negedge CLOCK_50);
        check_outputs("reset");
        chk("reset_done", bus.done, 0);
        @(negedge CLOCK_50);
        Resetn = 1'b1;
        @(negedge CLOCK_50);
    endtask

    // Issue one start pulse (optionally a second one mid-scan) and score it.
    task automatic apply(input int r, input int c, input int p, input int extra_at);
        bit accept, valid, seen;
        int lat, busy_bad, done_after;
        accept = !m_win && !m_draw;
        valid  = (r >= 0 && r < ROWS && c >= 0 && c < COLS && (p == 1 || p == 2));
        if (accept && valid) bd[r][c] = p;
        bus.place_row = 3'(r);
        bus.place_col = 3'(c);
        bus.player    = 2'(p);
        bus.board     = pack_board();
        bus.start     = 1'b1;
        seen = 0; lat = 0; busy_bad = 0;
        @(negedge CLOCK_50);
        for (int i = 1; i <= 40; i++) begin
            bus.start = (i == extra_at);
            if (bus.done) begin
                seen = 1;
                lat  = i;
                break;
            end
            if (!bus.busy) busy_bad++;
            @(negedge CLOCK_50);
        end
        bus.start  = 1'b0;
        done_after = 0;
        for (int i = 0; i < 35; i++) begin
            @(negedge CLOCK_50);
            if (bus.done) done_after++;
        end
        if (!accept) begin
            chk("ignored_start_done", seen, 0);
        end else if (!valid) begin
            chk("bad_move_latency", seen ? lat : -1, 1);
        end else begin
            chk("scan_done_seen", seen, 1);
            chk("scan_latency_le_30", (seen && lat <= 30), 1);
            chk("busy_during_scan", busy_bad, 0);
            m_moves++;
            if (ref_win(r, c, p)) begin
                m_win    = 1;
                m_winner = p;
            end else if (m_moves == CELLS) begin
                m_draw = 1;
            end
        end
        chk("single_done_pulse", done_after, 0);
        check_outputs("move");
    endtask

    initial begin
        bus.start = 1'b0; bus.board = '0;
        bus.place_row = 3'd0; bus.place_col = 3'd0; bus.player = 2'b00;

        vecs[0]  = '{3'd3, {pc(5,0,1), pc(5,1,1), pc(5,2,1), 8'd0}, 3'd5, 3'd3, 2'd1, 1'b0, 1'b1, 2'b01};
        vecs[1]  = '{3'd3, {pc(5,6,2), pc(4,6,2), pc(3,6,2), 8'd0}, 3'd2, 3'd6, 2'd2, 1'b0, 1'b1, 2'b10};
        vecs[2]  = '{3'd3, {pc(5,6,1), pc(4,5,1), pc(3,4,1), 8'd0}, 3'd2, 3'd3, 2'd1, 1'b0, 1'b1, 2'b01};
        vecs[3]  = '{3'd3, {pc(5,6,1), pc(4,5,1), pc(3,4,2), 8'd0}, 3'd2, 3'd3, 2'd1, 1'b0, 1'b0, 2'b00};
        vecs[4]  = '{3'd3, {pc(5,0,1), pc(5,1,1), pc(5,3,1), 8'd0}, 3'd5, 3'd2, 2'd1, 1'b0, 1'b1, 2'b01};
        vecs[5]  = '{3'd3, {pc(5,0,2), pc(4,1,2), pc(3,2,2), 8'd0}, 3'd2, 3'd3, 2'd2, 1'b0, 1'b1, 2'b10};
        vecs[6]  = '{3'd2, {pc(0,1,1), pc(0,2,1), 16'd0},           3'd0, 3'd0, 2'd1, 1'b0, 1'b0, 2'b00};
        vecs[7]  = '{3'd3, {pc(0,4,1), pc(0,5,1), pc(1,0,1), 8'd0}, 3'd0, 3'd6, 2'd1, 1'b0, 1'b0, 2'b00};
        vecs[8]  = '{3'd3, {pc(5,0,2), pc(5,1,2), pc(5,2,2), 8'd0}, 3'd5, 3'd3, 2'd1, 1'b0, 1'b0, 2'b00};
        vecs[9]  = '{3'd0, 32'd0,                                   3'd0, 3'd7, 2'd1, 1'b1, 1'b0, 2'b00};
        vecs[10] = '{3'd0, 32'd0,                                   3'd6, 3'd0, 2'd1, 1'b1, 1'b0, 2'b00};
        vecs[11] = '{3'd0, 32'd0,                                   3'd5, 3'd0, 2'd3, 1'b1, 1'b0, 2'b00};
        vecs[12] = '{3'd0, 32'd0,                                   3'd5, 3'd0, 2'd0, 1'b1, 1'b0, 2'b00};
        vecs[13] = '{3'd3, {pc(3,2,1), pc(1,4,1), pc(0,5,1), 8'd0}, 3'd2, 3'd3, 2'd1, 1'b0, 1'b1, 2'b01};

        for (int v = 0; v < 14; v++) begin
            do_reset();
            for (int j = 0; j < int'(vecs[v].n); j++) begin
                logic [7:0] e;
                e = vecs[v].pcs[31-8*j -: 8];
                bd[e[7:5]][e[4:2]] = int'(e[1:0]);
            end
            apply(int'(vecs[v].row), int'(vecs[v].col), int'(vecs[v].pl), 0);
            chk("tbl_win",    bus.win,    vecs[v].exp_win);
            chk("tbl_winner", bus.winner, vecs[v].exp_winner);
            chk("tbl_moves",  bus.moves,  vecs[v].exp_bad ? 0 : 1);
        end

        // Second start while busy is ignored.
        do_reset();
        apply(5, 0, 1, 3);
        chk("busy_start_moves", bus.moves, 1);

        // Reset three cycles into a scan aborts it silently.
        do_reset();
        bd[5][0] = 1; bd[5][1] = 1; bd[5][2] = 1; bd[5][3] = 1;
        bus.place_row = 3'd5; bus.place_col = 3'd3; bus.player = 2'b01;
        bus.board = pack_board();
        bus.start = 1'b1;
        @(negedge CLOCK_50);
        bus.start = 1'b0;
        @(negedge CLOCK_50);
        chk("midscan_busy", bus.busy, 1);
        chk("midscan_moves", bus.moves, 1);
        @(negedge CLOCK_50);
        Resetn = 1'b0;
        #1;
        chk("midscan_rst_busy",  bus.busy,  0);
        chk("midscan_rst_moves", bus.moves, 0);
        chk("midscan_rst_win",   bus.win,   0);
        @(negedge CLOCK_50);
        Resetn = 1'b1;
        begin
            int dn = 0;
            for (int i = 0; i < 35; i++) begin
                @(negedge CLOCK_50);
                if (bus.done) dn++;
            end
            chk("midscan_no_done", dn, 0);
            chk("midscan_after_win", bus.win, 0);
            chk("midscan_after_moves", bus.moves, 0);
        end

        // Full board with no four-run ends in a draw.
        do_reset();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                apply(r, c, (((r + c / 2) % 2) != 0) ? 2 : 1, 0);
        chk("draw_flag",  bus.draw,  1);
        chk("draw_win",   bus.win,   0);
        chk("draw_moves", bus.moves, 42);
        apply(0, 0, 1, 0);

        // Random games.
        for (int g = 0; g < 6; g++) begin
            do_reset();
            for (int it = 0; it < 60; it++) begin
                int empties [$];
                if (m_win || m_draw) break;
                if ($urandom_range(0, 9) == 0) begin
                    int kind;
                    kind = $urandom_range(0, 2);
                    if (kind == 0)      apply(6, $urandom_range(0, 6), 1, 0);
                    else if (kind == 1) apply($urandom_range(0, 5), 7, 2, 0);
                    else                apply($urandom_range(0, 5), $urandom_range(0, 6),
                                              ($urandom_range(0, 1) != 0) ? 3 : 0, 0);
                end else begin
                    int idx;
                    for (int r = 0; r < ROWS; r++)
                        for (int c = 0; c < COLS; c++)
                            if (bd[r][c] == 0) empties.push_back(r * COLS + c);
                    if (empties.size() == 0) break;
                    idx = empties[$urandom_range(0, empties.size() - 1)];
                    apply(idx / COLS, idx % COLS, $urandom_range(1, 2),
                          ($urandom_range(0, 7) == 0) ? 3 : 0);
                end
            end
            if (m_win || m_draw) apply(0, 0, 1, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
